shader_memory: RTL and testbench



---
 rtl/shader_pkg.sv | 15 +
 rtl/shader_mem_bank.sv | 46 ++++
 rtl/shader_memory.sv | 182 ++++++++++++++++++
 tb/tb_shader_memory.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shader_pkg.sv
// Shared constants and types for the shader program memory.
// Holds the instruction width, default program depth, NOP encoding and FSM states.
package shader_pkg;

  localparam int SHADER_INSTR_W   = 8;
  localparam int SHADER_NUM_INSTR = 16;

  localparam logic [SHADER_INSTR_W-1:0] SHADER_NOP = 8'h00;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } shader_state_e;

endpackage

// File: rtl/shader_mem_bank.sv
// One rotating bank of instruction slots.
// A rotation moves every slot one step toward slot 0; the tail slot takes
// either the old head (recirculate) or data_i (insert). Slot 0 is the head.
module shader_mem_bank
  import shader_pkg::*;
#(
  parameter int                  NUM_INSTR     = SHADER_NUM_INSTR,
  parameter int                  INSTR_W       = SHADER_INSTR_W,
  parameter logic [INSTR_W-1:0]  DEFAULT_INSTR = INSTR_W'(SHADER_NOP)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rotate_i,
  input  logic               insert_i,
  input  logic [INSTR_W-1:0] data_i,
  output logic [INSTR_W-1:0] head_o
);

  logic [INSTR_W-1:0] mem_q [NUM_INSTR];
  logic [INSTR_W-1:0] tail_d;

  // Choose what enters the tail slot: a new byte on insert, else the old head.
  always_comb begin
    tail_d = mem_q[0];
    if (insert_i) begin
      tail_d = data_i;
    end
  end

  // Slot array: restore defaults on reset, otherwise shift one step per rotation.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_INSTR; k++) begin
        mem_q[k] <= DEFAULT_INSTR;
      end
    end else if (rotate_i) begin
      for (int k = 0; k < NUM_INSTR - 1; k++) begin
        mem_q[k] <= mem_q[k+1];
      end
      mem_q[NUM_INSTR-1] <= tail_d;
    end
  end

  assign head_o = mem_q[0];

endmodule

// File: rtl/shader_memory.sv
// Shader program memory: a circular instruction store fed by the SPI receiver
// and stepped by the executor. The head instruction is combinational from
// slot 0, pc_o tracks the head position and wrap_o pulses on pc wrap.
// A full reload takes NUM_INSTR load pulses.
// Optional macro SHADER_MEMORY_SHADOW_EN: a second bank receives reloads while
// the active bank keeps running; banks swap on the next pc wrap.
module shader_memory
  import shader_pkg::*;
#(
  parameter int                  NUM_INSTR     = SHADER_NUM_INSTR,
  parameter int                  INSTR_W       = SHADER_INSTR_W,
  parameter logic [INSTR_W-1:0]  DEFAULT_INSTR = INSTR_W'(SHADER_NOP)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         load_i,
  input  logic [INSTR_W-1:0]           instr_i,
  input  logic                         exec_shift_i,
  output logic [INSTR_W-1:0]           instr_o,
  output logic [$clog2(NUM_INSTR)-1:0] pc_o,
  output logic                         wrap_o,
  output logic                         valid_o
);

  localparam int PC_W  = $clog2(NUM_INSTR);
  localparam int CNT_W = PC_W + 1;

`ifdef SHADER_MEMORY_SHADOW_EN
  localparam int NUM_BANKS = 2;
`else
  localparam int NUM_BANKS = 1;
`endif

  localparam logic [PC_W-1:0]  LAST_PC   = PC_W'(NUM_INSTR - 1);
  localparam logic [CNT_W-1:0] LAST_LOAD = CNT_W'(NUM_INSTR - 1);

  shader_state_e      state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic               wrap_q, wrap_d;
  logic               valid_q, valid_d;

  logic [NUM_BANKS-1:0] bank_rotate;
  logic [NUM_BANKS-1:0] bank_insert;
  logic [INSTR_W-1:0]   bank_head [NUM_BANKS];

`ifdef SHADER_MEMORY_SHADOW_EN
  logic sel_q, sel_d;
  logic swap_pending_q, swap_pending_d;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    shader_mem_bank #(
      .NUM_INSTR     (NUM_INSTR),
      .INSTR_W       (INSTR_W),
      .DEFAULT_INSTR (DEFAULT_INSTR)
    ) u_bank (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rotate_i (bank_rotate[b]),
      .insert_i (bank_insert[b]),
      .data_i   (instr_i),
      .head_o   (bank_head[b])
    );
  end

  // Next-state logic: decides the single rotation per cycle, pc/wrap updates
  // and reload progress.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    load_cnt_d  = load_cnt_q;
    wrap_d      = 1'b0;
    valid_d     = valid_q;
    bank_rotate = '0;
    bank_insert = '0;
`ifdef SHADER_MEMORY_SHADOW_EN
    sel_d          = sel_q;
    swap_pending_d = swap_pending_q;

    if (exec_shift_i) begin
      bank_rotate[sel_q] = 1'b1;
      pc_d               = pc_q + 1'b1;
      wrap_d             = (pc_q == LAST_PC);
      if ((pc_q == LAST_PC) && swap_pending_q && !load_i) begin
        sel_d          = ~sel_q;
        swap_pending_d = 1'b0;
      end
    end

    if (load_i) begin
      bank_rotate[~sel_q] = 1'b1;
      bank_insert[~sel_q] = 1'b1;
      if (state_q == LOAD) begin
        if (load_cnt_q == LAST_LOAD) begin
          state_d        = RUN;
          load_cnt_d     = '0;
          swap_pending_d = 1'b1;
        end else begin
          load_cnt_d = load_cnt_q + 1'b1;
        end
      end else begin
        state_d        = LOAD;
        load_cnt_d     = CNT_W'(1);
        swap_pending_d = 1'b0;
      end
    end
`else
    case (state_q)
      RUN: begin
        if (load_i) begin
          bank_rotate[0] = 1'b1;
          bank_insert[0] = 1'b1;
          load_cnt_d     = CNT_W'(1);
          state_d        = LOAD;
          valid_d        = 1'b0;
        end else if (exec_shift_i) begin
          bank_rotate[0] = 1'b1;
          pc_d           = pc_q + 1'b1;
          wrap_d         = (pc_q == LAST_PC);
        end
      end
      LOAD: begin
        if (load_i) begin
          bank_rotate[0] = 1'b1;
          bank_insert[0] = 1'b1;
          if (load_cnt_q == LAST_LOAD) begin
            state_d    = RUN;
            pc_d       = '0;
            valid_d    = 1'b1;
            load_cnt_d = '0;
          end else begin
            load_cnt_d = load_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
`endif
  end

  // Control registers: FSM state, pc, load counter and status flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      pc_q       <= '0;
      load_cnt_q <= '0;
      wrap_q     <= 1'b0;
      valid_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      load_cnt_q <= load_cnt_d;
      wrap_q     <= wrap_d;
      valid_q    <= valid_d;
    end
  end

`ifdef SHADER_MEMORY_SHADOW_EN
  // Bank select and pending-swap flag for the double-buffered reload.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q          <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      sel_q          <= sel_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign instr_o = bank_head[sel_q];
`else
  assign instr_o = bank_head[0];
`endif

  assign pc_o    = pc_q;
  assign wrap_o  = wrap_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_shader_memory.sv
// Testbench for shader_memory with a four-slot program.
// Stimulus pushes the expected post-edge outputs into a queue; a monitor
// pops and compares them just after each rising edge.
module tb_shader_memory;

  localparam int N  = 4;
  localparam int PW = 2;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         load_i = 1'b0;
  logic [7:0]   instr_i = 8'h00;
  logic         exec_shift_i = 1'b0;
  logic [7:0]   instr_o;
  logic [PW-1:0] pc_o;
  logic         wrap_o;
  logic         valid_o;

  typedef struct {
    logic [7:0]    instr;
    logic [PW-1:0] pc;
    logic          wrap;
    logic          valid;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   cycleNo = 0;

  shader_memory #(
    .NUM_INSTR     (N),
    .INSTR_W       (8),
    .DEFAULT_INSTR (8'h00)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (load_i),
    .instr_i      (instr_i),
    .exec_shift_i (exec_shift_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .wrap_o       (wrap_o),
    .valid_o      (valid_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Compares the current DUT outputs against one expected entry.
  task automatic checkOutput(input exp_t e);
    checks++;
    if (instr_o !== e.instr) begin
      errors++;
      $display("[TB] FAIL instr_o at cycle %0d: got %h expected %h", cycleNo, instr_o, e.instr);
    end
    checks++;
    if (pc_o !== e.pc) begin
      errors++;
      $display("[TB] FAIL pc_o at cycle %0d: got %0d expected %0d", cycleNo, pc_o, e.pc);
    end
    checks++;
    if (wrap_o !== e.wrap) begin
      errors++;
      $display("[TB] FAIL wrap_o at cycle %0d: got %b expected %b", cycleNo, wrap_o, e.wrap);
    end
    checks++;
    if (valid_o !== e.valid) begin
      errors++;
      $display("[TB] FAIL valid_o at cycle %0d: got %b expected %b", cycleNo, valid_o, e.valid);
    end
  endtask

  // Drives one cycle of inputs and queues the outputs expected after the edge.
  task automatic applyStimulus(input logic ld, input logic [7:0] din, input logic ex,
                               input logic [7:0] eInstr, input int ePc,
                               input logic eWrap, input logic eValid);
    exp_t e;
    @(negedge clk_i);
    load_i       = ld;
    instr_i      = din;
    exec_shift_i = ex;
    e.instr = eInstr;
    e.pc    = ePc[PW-1:0];
    e.wrap  = eWrap;
    e.valid = eValid;
    expQ.push_back(e);
  endtask

  // Asserts reset across one rising edge and expects default outputs.
  task automatic doReset();
    exp_t e;
    @(negedge clk_i);
    rst_i        = 1'b1;
    load_i       = 1'b0;
    exec_shift_i = 1'b0;
    e.instr = 8'h00;
    e.pc    = '0;
    e.wrap  = 1'b0;
    e.valid = 1'b1;
    expQ.push_back(e);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Monitor: pops one expectation per cycle just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      cycleNo++;
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus.
  initial begin
    doReset();
`ifdef SHADER_MEMORY_SHADOW_EN
    // Load P into the shadow bank; active bank keeps showing defaults.
    applyStimulus(1, 8'h11, 0, 8'h00, 0, 0, 1);
    applyStimulus(1, 8'h22, 0, 8'h00, 0, 0, 1);
    applyStimulus(1, 8'h33, 0, 8'h00, 0, 0, 1);
    applyStimulus(1, 8'h44, 0, 8'h00, 0, 0, 1);
    // Run to the wrap; the swap brings P to the head.
    applyStimulus(0, 8'h00, 1, 8'h00, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 2, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 3, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h11, 0, 1, 1);
    applyStimulus(0, 8'h00, 1, 8'h22, 1, 0, 1);
    // Load Q while P keeps executing; Q appears at the next wrap.
    applyStimulus(1, 8'h55, 1, 8'h33, 2, 0, 1);
    applyStimulus(1, 8'h66, 1, 8'h44, 3, 0, 1);
    applyStimulus(1, 8'h77, 1, 8'h11, 0, 1, 1);
    applyStimulus(1, 8'h88, 1, 8'h22, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h33, 2, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h44, 3, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h55, 0, 1, 1);
    applyStimulus(0, 8'h00, 1, 8'h66, 1, 0, 1);
`else
    // Five exec shifts over the default program: one wrap.
    applyStimulus(0, 8'h00, 1, 8'h00, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 2, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 3, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 0, 1, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 1, 0, 1);
    applyStimulus(0, 8'h00, 0, 8'h00, 1, 0, 1);
    // Full reload A1..A4, then run it through one wrap.
    applyStimulus(1, 8'hA1, 0, 8'h00, 1, 0, 0);
    applyStimulus(1, 8'hA2, 0, 8'h00, 1, 0, 0);
    applyStimulus(1, 8'hA3, 0, 8'h00, 1, 0, 0);
    applyStimulus(1, 8'hA4, 0, 8'hA1, 0, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'hA2, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'hA3, 2, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'hA4, 3, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'hA1, 0, 1, 1);
    applyStimulus(0, 8'h00, 1, 8'hA2, 1, 0, 1);
    // Reload with exec held high: pc frozen, no wrap, one rotation per load.
    applyStimulus(1, 8'hB1, 1, 8'hA3, 1, 0, 0);
    applyStimulus(1, 8'hB2, 1, 8'hA4, 1, 0, 0);
    applyStimulus(0, 8'h00, 1, 8'hA4, 1, 0, 0);
    applyStimulus(1, 8'hB3, 1, 8'hA1, 1, 0, 0);
    applyStimulus(1, 8'hB4, 1, 8'hB1, 0, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'hB2, 1, 0, 1);
    // Partial reload interrupted by reset.
    applyStimulus(1, 8'hC1, 0, 8'hB3, 1, 0, 0);
    applyStimulus(1, 8'hC2, 0, 8'hB4, 1, 0, 0);
    doReset();
    applyStimulus(0, 8'h00, 1, 8'h00, 1, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 2, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 3, 0, 1);
    applyStimulus(0, 8'h00, 1, 8'h00, 0, 1, 1);
`endif
    @(negedge clk_i);
    load_i       = 1'b0;
    exec_shift_i = 1'b0;
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(negedge clk_i);
    end
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
